// File: rtl/burst_data_former.sv
// Burst test-data former: counter/LFSR word bursts; optional XOR checksum word under BURST_DATA_FORMER_CSUM_EN.
// Latency: first word valid the cycle after start_send, then one word per cycle while ready is high.
// Backpressure: valid/data/last hold while ready is low; start_send/next_count are ignored while busy.
module burst_data_former #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_BURST_MAX  = 16,
  parameter logic [P_DATA_WIDTH-1:0] P_LFSR_TAPS = 'hB8
) (
  input  logic                               clk_100,
  input  logic                               a_rst,
  input  logic                               s_rst,
  input  logic                               next_count,
  input  logic                               start_send,
  input  logic                               mode,
  input  logic [$clog2(P_BURST_MAX+1)-1:0]   burst_len,
  input  logic                               ready,
  output logic                               valid,
  output logic [P_DATA_WIDTH-1:0]            data,
  output logic                               last,
  output logic                               busy,
  output logic                               done
);
  localparam int W  = P_DATA_WIDTH;
  localparam int LW = $clog2(P_BURST_MAX+1);
  localparam logic [LW-1:0] LEN_MAX = LW'(P_BURST_MAX);

`ifdef BURST_DATA_FORMER_CSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
  logic [W-1:0] csum;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif

  state_t        state, state_nxt;
  logic [W-1:0]  seed, cur;
  logic [LW-1:0] cnt, len_q;
  logic          mode_q, done_q;
  logic          len_ok, is_final;
  logic          start_ok, step_seed, pay_xfer, burst_end;

  // A zero LFSR state would lock up, so it is promoted to 1 before stepping.
  function automatic logic [W-1:0] step(input logic [W-1:0] x, input logic m);
    logic [W-1:0] y;
    y = (m && x == '0) ? W'(1) : x;
    if (!m)
      return x + W'(1);
    return (y >> 1) ^ (y[0] ? P_LFSR_TAPS : '0);
  endfunction

  assign len_ok   = (burst_len != '0) && (burst_len <= LEN_MAX);
  assign is_final = (cnt == len_q - LW'(1));
  assign busy     = (state != IDLE);
  assign done     = done_q;

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst)
      state <= IDLE;
    else if (s_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    data      = '0;
    last      = 1'b0;
    start_ok  = 1'b0;
    step_seed = 1'b0;
    pay_xfer  = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (start_send && len_ok) begin
          start_ok  = 1'b1;
          state_nxt = SEND;
        end else if (next_count) begin
          step_seed = 1'b1;
        end
      end
      SEND: begin
        valid    = 1'b1;
        data     = cur;
        pay_xfer = ready;
`ifdef BURST_DATA_FORMER_CSUM_EN
        if (ready && is_final)
          state_nxt = CSUM;
`else
        last = is_final;
        if (ready && is_final) begin
          state_nxt = IDLE;
          burst_end = 1'b1;
        end
`endif
      end
`ifdef BURST_DATA_FORMER_CSUM_EN
      CSUM: begin
        valid = 1'b1;
        data  = csum;
        last  = 1'b1;
        if (ready) begin
          state_nxt = IDLE;
          burst_end = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst || s_rst) begin
      seed   <= '0;
      cur    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
`ifdef BURST_DATA_FORMER_CSUM_EN
      csum   <= '0;
`endif
    end else begin
      done_q <= burst_end;
      if (start_ok) begin
        mode_q <= mode;
        len_q  <= burst_len;
        cur    <= (mode && seed == '0) ? W'(1) : seed;
        cnt    <= '0;
`ifdef BURST_DATA_FORMER_CSUM_EN
        csum   <= '0;
`endif
      end else if (step_seed) begin
        seed <= step(seed, mode);
      end
      if (pay_xfer) begin
        cur <= step(cur, mode_q);
        cnt <= cnt + LW'(1);
`ifdef BURST_DATA_FORMER_CSUM_EN
        csum <= csum ^ cur;
`endif
        // The next burst resumes the sequence right after this burst's last word.
        if (is_final)
          seed <= step(cur, mode_q);
      end
    end
  end

endmodule

// File: tb/tb_burst_data_former.sv
// Bench for burst_data_former: vector table plus hand-written corner sequences, scoreboard on transfers.
`timescale 1ns/1ps
module tb_burst_data_former;
  localparam int W  = 8;
  localparam int BM = 16;
  localparam int LW = $clog2(BM+1);
`ifdef BURST_DATA_FORMER_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk_100 = 1'b0;
  logic          a_rst, s_rst, next_count, start_send, mode, ready;
  logic [LW-1:0] burst_len;
  logic          valid, last, busy, done;
  logic [W-1:0]  data;

  always #5 clk_100 = ~clk_100;

  burst_data_former #(.P_DATA_WIDTH(W), .P_BURST_MAX(BM), .P_LFSR_TAPS(8'hB8)) dut (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst), .next_count(next_count),
    .start_send(start_send), .mode(mode), .burst_len(burst_len), .ready(ready),
    .valid(valid), .data(data), .last(last), .busy(busy), .done(done)
  );

  typedef struct packed {logic [W-1:0] d; logic l;} word_t;
  typedef struct {
    logic rst; int steps; logic mode; int len; logic rnd; logic acc;
    logic [W-1:0] first; logic [W-1:0] lastw;
  } vec_t;

  int           errors = 0;
  int           checks = 0;
  word_t        exp_q[$];
  logic [W-1:0] rx[$];
  logic [W-1:0] m_seed;
  int           n_done = 0;
  logic         stall_q = 1'b0;
  word_t        stall_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] f_step(input logic [W-1:0] x, input logic m);
    logic [W-1:0] y;
    if (!m) return x + 8'd1;
    y = (x == 8'd0) ? 8'd1 : x;
    return {1'b0, y[W-1:1]} ^ (y[0] ? 8'hB8 : 8'h00);
  endfunction

  // Scoreboard: every accepted word is compared against the model queue.
  always @(negedge clk_100) begin
    word_t w;
    if (done) n_done++;
    if (stall_q && valid) check("hold_stable", 32'({data, last}), 32'(stall_w));
    stall_q = valid && !ready;
    stall_w = {data, last};
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(data), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("word(data,last)", 32'({data, last}), 32'(w));
      end
      rx.push_back(data);
    end
  end

  task automatic tick();
    @(posedge clk_100); #1;
  endtask

  task automatic do_reset();
    a_rst = 1'b1; s_rst = 1'b0; next_count = 1'b0; start_send = 1'b0;
    mode = 1'b0; burst_len = '0; ready = 1'b0;
    repeat (2) @(posedge clk_100);
    #1 a_rst = 1'b0;
    exp_q.delete(); rx.delete(); m_seed = '0; stall_q = 1'b0;
  endtask

  task automatic steps(input int n, input logic m);
    next_count = 1'b1; mode = m;
    repeat (n) tick();
    next_count = 1'b0;
    for (int i = 0; i < n; i++) m_seed = f_step(m_seed, m);
  endtask

  task automatic push_burst(input logic m, input int len);
    logic [W-1:0] c, cs;
    c  = (m && m_seed == 8'd0) ? 8'd1 : m_seed;
    cs = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({c, (i == len-1) && !CS});
      cs ^= c;
      if (i == len-1) m_seed = f_step(c, m);
      c = f_step(c, m);
    end
    if (CS) exp_q.push_back({cs, 1'b1});
  endtask

  task automatic start(input logic m, input int len);
    mode = m; burst_len = LW'(len); start_send = 1'b1;
    if (len >= 1 && len <= BM) push_burst(m, len);
    tick();
    start_send = 1'b0;
  endtask

  task automatic wait_done(input logic rnd);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk_100); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      @(negedge clk_100); #1;
      if (done) break;
    end
    check("done_seen", 32'(k < 300), 32'd1);
    check("busy_low_in_done", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    ready = 1'b1;
  endtask

  vec_t vt[8];
  int   nd0;

  initial begin
    vt[0] = '{1'b1, 3,   1'b0, 4,  1'b0, 1'b1, 8'h03, 8'h06};
    vt[1] = '{1'b0, 0,   1'b0, 1,  1'b0, 1'b1, 8'h07, 8'h07};
    vt[2] = '{1'b1, 0,   1'b1, 4,  1'b0, 1'b1, 8'h01, 8'h2E};
    vt[3] = '{1'b0, 0,   1'b1, 2,  1'b1, 1'b1, 8'h17, 8'hB3};
    vt[4] = '{1'b1, 255, 1'b0, 2,  1'b0, 1'b1, 8'hFF, 8'h00};
    vt[5] = '{1'b0, 0,   1'b0, 16, 1'b1, 1'b1, 8'h01, 8'h10};
    vt[6] = '{1'b0, 0,   1'b0, 0,  1'b0, 1'b0, 8'h00, 8'h00};
    vt[7] = '{1'b0, 0,   1'b0, 17, 1'b0, 1'b0, 8'h00, 8'h00};

    a_rst = 1'b1; s_rst = 1'b0; next_count = 1'b0; start_send = 1'b0;
    mode = 1'b0; burst_len = '0; ready = 1'b0;
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data",  32'(data),  32'd0);
    check("rst_last",  32'(last),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      if (vt[i].rst) do_reset();
      if (vt[i].steps > 0) steps(vt[i].steps, 1'b0);
      rx.delete();
      ready = 1'b1;
      start(vt[i].mode, vt[i].len);
      if (vt[i].acc) begin
        check("first_valid", 32'(valid), 32'd1);
        check("first_busy",  32'(busy),  32'd1);
        check("first_data",  32'(data),  32'(vt[i].first));
        wait_done(vt[i].rnd);
        check("rx_count", 32'(rx.size()), 32'(vt[i].len + int'(CS)));
        check("rx_first", 32'(rx[0]), 32'(vt[i].first));
        check("rx_last_payload", 32'(rx[vt[i].len-1]), 32'(vt[i].lastw));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
      end else begin
        check("bad_len_busy",  32'(busy),  32'd0);
        check("bad_len_valid", 32'(valid), 32'd0);
      end
    end

    // Backpressure: ready low for three cycles after the first word.
    do_reset();
    steps(3, 1'b0);
    ready = 1'b1;
    start(1'b0, 4);
    tick();
    ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_data",  32'(data),  32'h04);
    end
    ready = 1'b1;
    wait_done(1'b0);

    // start+next_count together, start/next during SEND, back-to-back start in done cycle.
    do_reset();
    next_count = 1'b1;
    start(1'b0, 2);
    next_count = 1'b0;
    check("start_wins_data", 32'(data), 32'h00);
    start_send = 1'b1; next_count = 1'b1; burst_len = LW'(5);
    tick();
    start_send = 1'b0; next_count = 1'b0;
    check("busy_ignore_data", 32'(data), 32'h00);
    ready = 1'b1;
    wait_done(1'b0);
    start(1'b0, 1);
    check("b2b_valid", 32'(valid), 32'd1);
    check("b2b_data",  32'(data),  32'h02);
    wait_done(1'b0);

    // Asynchronous reset mid-burst.
    do_reset();
    ready = 1'b1;
    start(1'b0, 4);
    tick(); tick();
    nd0 = n_done;
    #2 a_rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_data",  32'(data),  32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_last",  32'(last),  32'd0);
    a_rst = 1'b0;
    exp_q.delete(); m_seed = '0;
    repeat (3) tick();
    check("arst_no_done", 32'(n_done), 32'(nd0));
    start(1'b0, 1);
    check("arst_seed_cleared", 32'(data), 32'h00);
    wait_done(1'b0);

    // Synchronous reset mid-burst: takes effect only at the next edge.
    tick();
    start(1'b0, 4);
    tick(); tick();
    nd0 = n_done;
    ready = 1'b0; s_rst = 1'b1;
    #1;
    check("srst_before_edge_valid", 32'(valid), 32'd1);
    tick();
    s_rst = 1'b0;
    check("srst_valid", 32'(valid), 32'd0);
    check("srst_busy",  32'(busy),  32'd0);
    check("srst_data",  32'(data),  32'd0);
    exp_q.delete(); m_seed = '0;
    ready = 1'b1;
    repeat (3) tick();
    check("srst_no_done", 32'(n_done), 32'(nd0));
    start(1'b0, 1);
    check("srst_seed_cleared", 32'(data), 32'h00);
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_data_former.md
# burst_data_former

Parametrised successor to the single-word test-data former. It generates bursts of up to `P_BURST_MAX` words over a valid/ready stream toward the SPI transmit path. Two selectable patterns are supported: an incrementing counter and a Galois LFSR. A persistent seed register lets consecutive bursts continue one sequence. An optional checksum word can be appended to each burst.

## Interface
Parameters:
- `P_DATA_WIDTH`, 8, word width (≥ 2)
- `P_BURST_MAX`, 16, maximum payload words per burst (≥ 1)
- `P_LFSR_TAPS`, 8'hB8, Galois feedback mask, `P_DATA_WIDTH` bits

Ports:
- `clk_100`  in  1  system clock, all logic on rising edge
- `a_rst`  in  1  reset, asynchronous, active-high
- `s_rst`  in  1  synchronous reset, active-high; same effect as `a_rst`
- `next_count`  in  1  advance seed one step (IDLE only)
- `start_send`  in  1  start a burst (IDLE only)
- `mode`  in  1  0 = counter, 1 = LFSR; sampled at `start_send`
- `burst_len`  in  `$clog2(P_BURST_MAX+1)`  payload words; sampled at `start_send`
- `ready`  in  1  downstream accepts word
- `valid`  out  1  `data` holds a word
- `data`  out  `P_DATA_WIDTH`  word
- `last`  out  1  current word is the final word of the burst
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse after the final word is transferred

## Operation
- Registers: `seed`, `cur`, `cnt`, `mode_q`, `len_q`, `csum`, and FSM state (IDLE, SEND, CSUM).
- Step function: counter mode gives `x+1` mod 2^W. LFSR mode gives `(x>>1) ^ (x[0] ? P_LFSR_TAPS : 0)`. In LFSR mode a zero operand is replaced by 1 before use.
- IDLE, `next_count`=1: `seed <= step(seed)` using the current `mode` input.
- IDLE, `start_send`=1 with `burst_len` in 1..`P_BURST_MAX`:
  - Latch `mode` and `len`.
  - `cur <= seed` (or 1 if LFSR mode and seed is 0).
  - `cnt <= 0`, `csum <= 0`.
  - Go to SEND.
- IDLE, `start_send` with `burst_len`=0 or >`P_BURST_MAX`: ignored; no state change.
- `start_send` and `next_count` asserted in the same cycle: `start_send` wins and the seed is not stepped.
- SEND:
  - `valid`=1 and `data`=`cur`.
  - On `valid && ready`: `cur <= step(cur)`, `cnt++`, `csum ^= cur`.
  - On transfer of payload word `len_q-1`: `seed <= step(cur)`. Then go to IDLE, or to CSUM if the macro is defined.
- CSUM (macro only): `valid`=1, `data`=`csum`, `last`=1. On `ready`, go to IDLE.
- `start_send` and `next_count` are ignored while `busy`.
- `ready` asserted while `valid`=0 has no effect.

## Timing
- Reset values: `valid`=0, `data`=0, `last`=0, `busy`=0, `done`=0, `seed`=0, state IDLE.
- `start_send` is sampled at edge N. From cycle N+1, `valid`=1, `busy`=1, and the first word is on `data`.
- With `ready` held high, one word transfers per cycle. Burst of L words occupies cycles N+1..N+L, or N+L+1 with the checksum word.
- `valid` is asserted and then held until accepted. `data` and `last` stay stable while `valid && !ready`.
- `done`=1 for exactly the cycle after the final transfer. `busy` falls in that same cycle.
- A new `start_send` is accepted in the `done` cycle.
- `a_rst` mid-burst clears everything immediately. `s_rst` mid-burst clears at the next edge. The burst is dropped with no `done`.
- Counter wraps: 2^W−1 → 0.

## Configuration
- `BURST_DATA_FORMER_CSUM_EN` defined:
  - After the L payload words, one extra word equal to the XOR of all payload words is sent.
  - `last` is asserted only on the checksum word.
- `BURST_DATA_FORMER_CSUM_EN` not defined:
  - No CSUM state and no `csum` register.
  - `last` is asserted on payload word L.

## Test plan
- Counter: reset, `next_count` high 3 cycles (seed=3), `start_send` with len=4, mode=0, `ready`=1 → `data` 3,4,5,6; `last` on 6; `done` next cycle; seed=7.
- LFSR: reset (seed 0), `start_send` with len=4, mode=1 → `data` 01,B8,5C,2E; next burst starts at 17.
- Checksum (macro on): counter burst 3,4,5,6 → fifth word 04 with `last`=1. Macro off → `last` on 06, only 4 words.
- Backpressure: `ready` low 3 cycles mid-burst → `valid`=1 and `data` frozen. Word sequence unchanged after `ready` returns.
- Wrap and boundaries: seed=FF, len=2, mode=0 → FF,00. len=0 → no `busy`. `start_send` during SEND is ignored.
- Reset mid-burst: `a_rst` pulse after word 2 → all outputs 0 asynchronously, no `done`. Repeat with `s_rst` → cleared at the next edge.
